// File: rtl/sparc_trap_pkg.sv
// Shared types for the trap vector unit.
// State encoding and vector offset constant.
package sparc_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VECTOR = 2'd1,
    ST_ERROR  = 2'd2
  } trap_state_e;

  localparam logic [3:0] VEC_OFFSET = 4'b0000;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder, index 0 highest.
// One-hot grant of the lowest set request bit.
module prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic               valid_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o   = req_i & (~req_i + NUM_SRC'(1));
  assign valid_o = |req_i;

endmodule

// File: rtl/trap_vector_unit.sv
// Trap vector unit: sticky pending, priority pick,
// TBR image and valid/ready vector hand-off.
module trap_vector_unit
  import sparc_trap_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TT_W    = 8,
  parameter int NUM_SRC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      trap_req,
  input  logic [NUM_SRC*TT_W-1:0] trap_tt,
  input  logic                    et,
  input  logic                    wr_tba,
  input  logic [ADDR_W-1:0]       wr_data,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [ADDR_W-1:0]       vec_addr,
  output logic [ADDR_W-1:0]       tbr_out,
  output logic                    error_mode,
  output logic [NUM_SRC-1:0]      pending
);

  localparam int TBA_W = ADDR_W - TT_W - 4;

  if (TBA_W < 1) begin : g_bad_cfg
    $error("trap_vector_unit: ADDR_W too small for TT_W");
  end

  trap_state_e        state_q, state_d;
  logic [TBA_W-1:0]   tba_q, tba_d;
  logic [TBA_W-1:0]   snap_q, snap_d;
  logic [TT_W-1:0]    tt_q, tt_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;

  logic [NUM_SRC-1:0] gnt;
  logic               gnt_vld;
  logic [NUM_SRC-1:0] clr;
  logic [TT_W-1:0]    sel_tt;
  logic               unused_wr_lsb;

  assign unused_wr_lsb = ^wr_data[TT_W+3:0];

  prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req_i   (pend_q),
    .gnt_o   (gnt),
    .valid_o (gnt_vld)
  );

  // Mux the trap type of the granted source.
  always_comb begin
    sel_tt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) sel_tt = sel_tt | trap_tt[i*TT_W +: TT_W];
    end
  end

  // Next state, TT/snapshot capture and pending clear.
  always_comb begin
    state_d = state_q;
    tt_d    = tt_q;
    snap_d  = snap_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          if (et) begin
            state_d = ST_VECTOR;
            tt_d    = sel_tt;
            snap_d  = tba_q;
            clr     = gnt;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_VECTOR: begin
        if (vec_ready) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new request beats a same-cycle clear.
  always_comb begin
    pend_d = (pend_q & ~clr) | trap_req;
  end

  // TBA is writable in every state.
  always_comb begin
    tba_d = tba_q;
    if (wr_tba) tba_d = wr_data[ADDR_W-1 -: TBA_W];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tba_q   <= '0;
      snap_q  <= '0;
      tt_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      tba_q   <= tba_d;
      snap_q  <= snap_d;
      tt_q    <= tt_d;
      pend_q  <= pend_d;
    end
  end

  assign vec_valid  = (state_q == ST_VECTOR);
  assign error_mode = (state_q == ST_ERROR);
  assign vec_addr   = {snap_q, tt_q, VEC_OFFSET};
  assign tbr_out    = {tba_q, tt_q, VEC_OFFSET};
  assign pending    = pend_q;

endmodule
